// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between N_REQ byte sources.
//               Round-robin grant with packet lock: the granted requester
//               keeps the transmitter until it sends a byte flagged last.
//               A watchdog releases the transmitter when uart_tx stops
//               answering, or when a locked owner stops supplying bytes.
// Ports       : i_clock / i_reset  clock, synchronous active-high reset
//               i_req, i_data,     per-requester byte available, byte
//               i_last             (k at [k*NB_DATA +: NB_DATA]), end of packet
//               o_ack              one-cycle pop pulse to the served requester
//               o_grant            one-hot owner, zero when free
//               o_tx_data,         byte and start pulse to uart_tx
//               o_tx_start
//               i_tx_done          one-cycle pulse from uart_tx after stop bit
//               o_busy             arbiter not idle
//               o_timeout          one-cycle pulse on watchdog release
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int NB_DATA = 8,
    parameter int NB_TO   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    input  logic [N_REQ-1:0]         i_last,
    output logic [N_REQ-1:0]         o_ack,
    output logic [N_REQ-1:0]         o_grant,
    output logic [NB_DATA-1:0]       o_tx_data,
    output logic                     o_tx_start,
    input  logic                     i_tx_done,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int                  c_NB_IDX   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [NB_TO-1:0]    c_TIMEOUT  = NB_TO'(TIMEOUT);
    localparam logic [c_NB_IDX-1:0] c_LAST_IDX = c_NB_IDX'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_LOCKED    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_NB_IDX-1:0]   r_rr_ptr;
    logic [c_NB_IDX-1:0]   r_owner;
    logic                  r_last_q;
    logic [NB_TO-1:0]      r_wd;
    logic [N_REQ-1:0]      r_ack;
    logic [N_REQ-1:0]      r_grant;
    logic [NB_DATA-1:0]    r_tx_data;
    logic                  r_tx_start;
    logic                  r_busy;
    logic                  r_timeout;

    logic                  w_rr_found;
    logic [c_NB_IDX-1:0]   w_rr_idx;
    logic                  w_take;
    logic [c_NB_IDX-1:0]   w_take_idx;
    logic [N_REQ-1:0]      w_onehot;
    logic [NB_DATA-1:0]    w_take_data;
    logic                  w_release;
    logic                  w_timeout;
    logic                  w_tx_start;
    logic                  w_wd_clr;
    logic                  w_wd_inc;
    logic                  w_wd_hit;
    logic [c_NB_IDX-1:0]   w_ptr_after_owner;

    // (base + off) mod N_REQ, with off in [0, N_REQ-1]
    function automatic logic [c_NB_IDX-1:0] f_wrap_add(input logic [c_NB_IDX-1:0] base,
                                                       input int off);
        int v_sum;
        v_sum = int'(base) + off;
        if (v_sum >= N_REQ) begin
            v_sum = v_sum - N_REQ;
        end
        return c_NB_IDX'(v_sum);
    endfunction

    // Round-robin scan starting at r_rr_ptr. Walking the offsets from the
    // highest down lets the lowest offset with a request win.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[f_wrap_add(r_rr_ptr, i)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = f_wrap_add(r_rr_ptr, i);
            end
        end
    end

    // The watchdog fires on the edge where wd would reach TIMEOUT, so the
    // pulse appears TIMEOUT cycles after entering WAIT_DONE or LOCKED.
    assign w_wd_hit          = ((r_wd + NB_TO'(1)) == c_TIMEOUT);
    assign w_ptr_after_owner = (r_owner == c_LAST_IDX) ? '0 : (r_owner + 1'b1);
    assign w_onehot          = N_REQ'(1) << w_take_idx;
    assign w_take_data       = i_data[w_take_idx*NB_DATA +: NB_DATA];

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_take_idx   = r_owner;
        w_release    = 1'b0;
        w_timeout    = 1'b0;
        w_tx_start   = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rr_found) begin
                    w_take       = 1'b1;
                    w_take_idx   = w_rr_idx;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_start   = 1'b1;
                w_wd_clr     = 1'b1;
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done arriving on the timeout edge wins over the watchdog
                if (i_tx_done) begin
                    if (r_last_q) begin
                        w_release    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_wd_clr     = 1'b1;
                        w_state_next = S_LOCKED;
                    end
                end else if (w_wd_hit) begin
                    w_timeout    = 1'b1;
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            S_LOCKED: begin
                // Only the owner may continue its packet
                if (i_req[r_owner]) begin
                    w_take       = 1'b1;
                    w_take_idx   = r_owner;
                    w_state_next = S_START;
                end else if (w_wd_hit) begin
                    w_timeout    = 1'b1;
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_last_q   <= 1'b0;
            r_wd       <= '0;
            r_ack      <= '0;
            r_grant    <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_busy     <= (w_state_next != S_IDLE);
            r_tx_start <= w_tx_start;
            r_timeout  <= w_timeout;
            r_ack      <= '0;
            if (w_take) begin
                r_owner   <= w_take_idx;
                r_grant   <= w_onehot;
                r_tx_data <= w_take_data;
                r_last_q  <= i_last[w_take_idx];
                r_ack     <= w_onehot;
            end
            if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= w_ptr_after_owner;
            end
            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + NB_TO'(1);
            end
        end
    end

    assign o_ack      = r_ack;
    assign o_grant    = r_grant;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Requester byte
//               queues are loaded per phase; a transaction-level model
//               predicts the sequence of starts and timeouts into a
//               scoreboard, and a monitor compares DUT activity against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int NBD = 8;
    localparam int NBT = 16;
    localparam int TO  = 100;

    logic           i_clock   = 1'b0;
    logic           i_reset   = 1'b1;
    logic [N-1:0]   i_req     = '0;
    logic [N*NBD-1:0] i_data  = '0;
    logic [N-1:0]   i_last    = '0;
    logic           i_tx_done = 1'b0;
    logic [N-1:0]   o_ack;
    logic [N-1:0]   o_grant;
    logic [NBD-1:0] o_tx_data;
    logic           o_tx_start;
    logic           o_busy;
    logic           o_timeout;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .NB_DATA (NBD),
        .NB_TO   (NBT),
        .TIMEOUT (TO)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        bit         is_to;
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];          // expected starts / timeouts in order
    logic [8:0] rq[N][$];       // bytes presented to the DUT {last, data}
    logic [8:0] mq[N][$];       // model copy of the same bytes
    bit         dq[$];          // model: per-start "uart_tx never answers"
    bit         sq[$];          // stub copy of the same decisions
    int         m_ptr       = 0;
    int         fixed_delay = 0;
    int         stub_cnt    = 0;
    int         n_checks    = 0;
    int         n_errors    = 0;
    int         cyc = 0, ack_cyc = -10, start_cyc = -10, done_cyc = -10, n_starts = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input bit last, input bit drop);
        rq[k].push_back({last, d});
        mq[k].push_back({last, d});
        dq.push_back(drop);
        sq.push_back(drop);
    endtask

    // Transaction-level arbitration rules: round robin over packets from
    // m_ptr; an owner keeps going until a last byte, a missing done, or
    // running out of bytes mid-packet; the pointer then moves past it.
    task automatic model_run();
        int         k;
        logic [8:0] b;
        bit         dr;
        exp_t       e;
        forever begin
            k = -1;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (k < 0 && mq[c].size() > 0) k = c;
            end
            if (k < 0) break;
            forever begin
                b  = mq[k].pop_front();
                dr = dq.pop_front();
                e.is_to = 1'b0; e.idx = k; e.data = b[7:0];
                sb.push_back(e);
                if (dr || (!b[8] && mq[k].size() == 0)) begin
                    e.is_to = 1'b1; e.data = 8'h00;
                    sb.push_back(e);
                    break;
                end
                if (b[8]) break;
            end
            m_ptr = (k + 1) % N;
        end
    endtask

    task automatic load_random();
        int  npk, len;
        bit  unterm;
        for (int k = 0; k < N; k++) begin
            npk = $urandom_range(0, 2);
            for (int p = 0; p < npk; p++) begin
                len    = $urandom_range(1, 3);
                unterm = (p == npk - 1) && ($urandom_range(0, 5) == 0);
                for (int b = 0; b < len; b++) begin
                    push_byte(k, 8'($urandom), (b == len - 1) && !unterm,
                              $urandom_range(0, 7) == 0);
                end
            end
        end
    endtask

    function automatic bit all_rq_empty();
        for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget);
        int t = 0;
        @(posedge i_clock); #2;
        while (!(sb.size() == 0 && all_rq_empty() && !o_busy && stub_cnt == 0) && t < budget) begin
            @(posedge i_clock); #2;
            t++;
        end
        check(t < budget, "phase_drain", 32'(sb.size()), 32'd0);
        if (t >= budget) begin
            sb.delete(); sq.delete();
            for (int k = 0; k < N; k++) rq[k].delete();
        end
        repeat (3) @(posedge i_clock);
    endtask

    // Requesters and uart_tx stub, driven on the falling edge
    initial begin
        logic [8:0] junk;
        bit         d;
        forever begin
            @(negedge i_clock);
            for (int k = 0; k < N; k++) begin
                if (o_ack[k] && rq[k].size() > 0) junk = rq[k].pop_front();
                if (rq[k].size() > 0) begin
                    i_req[k]          = 1'b1;
                    i_data[k*NBD +: NBD] = rq[k][0][7:0];
                    i_last[k]         = rq[k][0][8];
                end else begin
                    i_req[k]  = 1'b0;
                    i_last[k] = 1'b0;
                end
            end
            i_tx_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start) begin
                d = (sq.size() > 0) ? sq.pop_front() : 1'b0;
                if (!d) stub_cnt = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 30);
            end
        end
    end

    // Monitor: samples one time unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clock); #1;
            cyc++;
            if (i_reset) begin
                check({o_ack, o_grant, o_tx_data, o_tx_start, o_busy, o_timeout} == '0,
                      "reset_outputs",
                      32'({o_ack, o_grant, o_tx_data, o_tx_start, o_busy, o_timeout}), 32'd0);
            end else begin
                check($onehot0(o_grant), "grant_onehot0", 32'(o_grant), 32'd0);
                check(o_busy == (o_grant != '0), "busy_vs_grant", 32'(o_busy), 32'(o_grant != '0));
                if (o_ack != '0) begin
                    check($onehot(o_ack) && o_ack == o_grant, "ack_matches_grant",
                          32'(o_ack), 32'(o_grant));
                    ack_cyc = cyc;
                end
                if (i_tx_done) done_cyc = cyc;
                if (o_tx_start) begin
                    n_starts++;
                    start_cyc = cyc;
                    check(cyc == ack_cyc + 1, "start_latency", 32'(cyc - ack_cyc), 32'd1);
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_start", 32'(o_grant), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check(!e.is_to && o_grant == (N'(1) << e.idx), "start_owner",
                              32'(o_grant), e.is_to ? 32'd0 : 32'(N'(1) << e.idx));
                        check(o_tx_data == e.data, "start_data", 32'(o_tx_data), 32'(e.data));
                    end
                end
                if (o_timeout) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_timeout", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check(e.is_to, "timeout_expected", 32'd1, 32'(e.is_to));
                    end
                    check(cyc == ((start_cyc > done_cyc) ? start_cyc : done_cyc) + TO,
                          "timeout_cycle", 32'(cyc),
                          32'(((start_cyc > done_cyc) ? start_cyc : done_cyc) + TO));
                    check(o_grant == '0, "timeout_grant_clear", 32'(o_grant), 32'd0);
                end
            end
        end
    end

    initial begin
        int s0, t;
        // Reset with every requester pending; first grant must go to req0
        for (int k = 0; k < N; k++) push_byte(k, 8'(8'h10 + k), 1'b1, 1'b0);
        model_run();
        @(negedge i_clock);
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        wait_idle(3000);

        // Single byte from req2, then pointer must sit at 3
        push_byte(2, 8'hA5, 1'b1, 1'b0);
        model_run();
        wait_idle(3000);
        push_byte(0, 8'h01, 1'b1, 1'b0);
        push_byte(3, 8'h03, 1'b1, 1'b0);
        model_run();
        wait_idle(3000);

        // Packet lock: req1 three bytes while req0/req3 wait
        push_byte(1, 8'h11, 1'b0, 1'b0);
        push_byte(1, 8'h12, 1'b0, 1'b0);
        push_byte(1, 8'h13, 1'b1, 1'b0);
        push_byte(0, 8'h20, 1'b1, 1'b0);
        push_byte(3, 8'h30, 1'b1, 1'b0);
        model_run();
        wait_idle(3000);
        push_byte(3, 8'h31, 1'b1, 1'b0);
        model_run();
        wait_idle(3000);

        // Watchdog in WAIT_DONE (no done for req0), then in LOCKED
        for (int k = 0; k < N; k++) push_byte(k, 8'(8'h40 + k), 1'b1, k == 0);
        model_run();
        wait_idle(3000);
        push_byte(0, 8'h50, 1'b0, 1'b0);
        push_byte(1, 8'h51, 1'b1, 1'b0);
        model_run();
        wait_idle(3000);

        for (int p = 0; p < 20; p++) begin
            load_random();
            model_run();
            wait_idle(6000);
        end

        // Reset mid-frame; the late done must be ignored
        fixed_delay = 8;
        push_byte(2, 8'h3C, 1'b1, 1'b0);
        model_run();
        s0 = n_starts;
        t  = 0;
        while (n_starts == s0 && t < 200) begin
            @(posedge i_clock); #2;
            t++;
        end
        check(t < 200, "midframe_start_seen", 32'(t), 32'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        m_ptr   = 0;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        repeat (30) @(posedge i_clock);
        #2;
        check(n_starts == s0 + 1, "no_start_after_reset", 32'(n_starts - s0), 32'd1);
        check(!o_busy && o_grant == '0, "idle_after_reset", 32'({o_busy, o_grant}), 32'd0);
        fixed_delay = 0;
        for (int k = 0; k < N; k++) push_byte(k, 8'(8'h60 + k), 1'b1, 1'b0);
        model_run();
        wait_idle(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
